// File: rtl/npc_bp.sv
// npc_bp: fetch PC register with next-PC prediction from a direct-mapped BTB
// with 2-bit saturating direction counters. Control transfers resolve in EX,
// where a wrong next-PC raises a one-cycle flush and redirects fetch.
module npc_bp #(
   parameter int unsigned     XLEN        = 32,
   parameter int unsigned     BTB_ENTRIES = 16,
   parameter logic [XLEN-1:0] RESET_PC    = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   output logic [XLEN-1:0] pc,
   output logic            pred_taken,
   output logic [XLEN-1:0] pred_target,
   input  logic            ex_valid,
   input  logic [XLEN-1:0] ex_pc,
   input  logic            ex_is_branch,
   input  logic            ex_is_jal,
   input  logic            ex_is_jalr,
   input  logic            ex_zero,
   input  logic [XLEN-1:0] ex_imm,
   input  logic [XLEN-1:0] ex_aluout,
   input  logic            ex_pred_taken,
   input  logic [XLEN-1:0] ex_pred_target,
   output logic            flush,
   output logic [31:0]     mispredict_cnt
);

   localparam int unsigned     IDX  = $clog2(BTB_ENTRIES);
   localparam int unsigned     TAGW = XLEN - IDX - 2;
   localparam logic [XLEN-1:0] FOUR = XLEN'(4);

   // Fetch PC and redirect counter.
   logic [XLEN-1:0] pc_q, pc_d;
   logic [31:0]     cnt_q, cnt_d;

   // BTB storage, one slot per index.
   logic            valid_q  [BTB_ENTRIES];
   logic [TAGW-1:0] tag_q    [BTB_ENTRIES];
   logic [XLEN-1:0] target_q [BTB_ENTRIES];
   logic [1:0]      ctr_q    [BTB_ENTRIES];

   // The travelling prediction bit is implied by ex_pred_target, which
   // already encodes both direction and target.
   logic unused_ex_pred_taken;
   assign unused_ex_pred_taken = ex_pred_taken;

   // Lookup on the current fetch PC (reads pre-update contents, no bypass).
   logic [IDX-1:0]  if_idx;
   logic [TAGW-1:0] if_tag;
   logic            if_hit;

   assign if_idx      = pc_q[IDX+1:2];
   assign if_tag      = pc_q[XLEN-1:IDX+2];
   assign if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
   assign pred_taken  = if_hit && ctr_q[if_idx][1];
   assign pred_target = pred_taken ? target_q[if_idx] : (pc_q + FOUR);
   assign pc          = pc_q;

   // Resolution of the EX instruction.
   logic            ex_any_ctl;
   logic            ex_ctl;
   logic            ex_plain;
   logic            act_taken;
   logic [XLEN-1:0] act_target;
   logic [XLEN-1:0] act_next;
   logic [IDX-1:0]  ex_idx;
   logic [TAGW-1:0] ex_tag;
   logic            ex_hit;

   assign ex_any_ctl = ex_is_branch | ex_is_jal | ex_is_jalr;
   assign ex_ctl     = ex_valid & ex_any_ctl;
   assign ex_plain   = ex_valid & ~ex_any_ctl;
   assign act_taken  = ex_is_jal | ex_is_jalr | (ex_is_branch & ex_zero);
   assign act_target = ex_is_jalr ? {ex_aluout[XLEN-1:1], 1'b0} : (ex_pc + ex_imm);
   assign act_next   = act_taken ? act_target : (ex_pc + FOUR);
   assign ex_idx     = ex_pc[IDX+1:2];
   assign ex_tag     = ex_pc[XLEN-1:IDX+2];
   assign ex_hit     = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

   // EX is ignored during reset so a pending redirect is dropped.
   assign flush = ex_valid & ~rst & (act_next != ex_pred_target);

   assign mispredict_cnt = cnt_q;

   // Next fetch PC: redirect beats stall, stall beats prediction.
   always_comb begin
      pc_d = pc_q;
      if (flush) begin
         pc_d = act_next;
      end else if (!stall) begin
         pc_d = pred_target;
      end
   end

   // Redirect counter saturates at all-ones.
   always_comb begin
      cnt_d = cnt_q;
      if (flush && (cnt_q != 32'hFFFF_FFFF)) begin
         cnt_d = cnt_q + 32'd1;
      end
   end

   // PC and counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q  <= RESET_PC;
         cnt_q <= '0;
      end else begin
         pc_q  <= pc_d;
         cnt_q <= cnt_d;
      end
   end

   // BTB training from EX; runs regardless of stall. A non-control
   // instruction that flushed hit a stale entry, so that entry is dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < BTB_ENTRIES; i++) begin
            valid_q[i] <= 1'b0;
            ctr_q[i]   <= 2'b01;
         end
      end else if (ex_ctl) begin
         if (ex_hit) begin
            if (act_taken) begin
               if (ctr_q[ex_idx] != 2'b11) begin
                  ctr_q[ex_idx] <= ctr_q[ex_idx] + 2'd1;
               end
               target_q[ex_idx] <= act_target;
            end else if (ctr_q[ex_idx] != 2'b00) begin
               ctr_q[ex_idx] <= ctr_q[ex_idx] - 2'd1;
            end
         end else if (act_taken) begin
            valid_q[ex_idx]  <= 1'b1;
            tag_q[ex_idx]    <= ex_tag;
            target_q[ex_idx] <= act_target;
            ctr_q[ex_idx]    <= 2'b10;
         end
      end else if (ex_plain && flush && ex_hit) begin
         valid_q[ex_idx] <= 1'b0;
      end
   end

endmodule

// File: tb/tb_npc_bp.sv
// Bench for npc_bp: a directed vector table walking the main scenarios, a
// hand-written counter-saturation sequence, and random traffic compared
// against a reference model of the predictor.
module tb_npc_bp;

   localparam int          N   = 16;
   localparam int          IDX = 4;
   localparam logic [31:0] RST_PC = 32'h0;

   // Clock and DUT signals.
   logic        clk = 1'b0;
   logic        rst, stall, ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr, ex_zero;
   logic        ex_pred_taken, pred_taken, flush;
   logic [31:0] pc, pred_target, ex_pc, ex_imm, ex_aluout, ex_pred_target, mispredict_cnt;

   always #5 clk = ~clk;

   npc_bp #(.XLEN(32), .BTB_ENTRIES(N), .RESET_PC(RST_PC)) dut (
      .clk(clk), .rst(rst), .stall(stall), .pc(pc),
      .pred_taken(pred_taken), .pred_target(pred_target),
      .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_is_branch(ex_is_branch),
      .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr), .ex_zero(ex_zero),
      .ex_imm(ex_imm), .ex_aluout(ex_aluout), .ex_pred_taken(ex_pred_taken),
      .ex_pred_target(ex_pred_target), .flush(flush), .mispredict_cnt(mispredict_cnt)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [31:0] tag;
      logic [31:0] target;
      int          ctr;
   } ent_t;

   ent_t        m_btb[int];   // absent key = invalid slot
   logic [31:0] m_pc  = '0;
   logic [31:0] m_cnt = '0;

   function automatic int idx_of(input logic [31:0] a);
      return int'((a >> 2) % N);
   endfunction

   function automatic logic [31:0] tag_of(input logic [31:0] a);
      return a >> (2 + IDX);
   endfunction

   function automatic bit m_hit(input logic [31:0] a);
      return m_btb.exists(idx_of(a)) && (m_btb[idx_of(a)].tag == tag_of(a));
   endfunction

   task automatic m_predict(input logic [31:0] a, output logic tk, output logic [31:0] tg);
      tk = 1'b0;
      tg = a + 32'd4;
      if (m_hit(a) && m_btb[idx_of(a)].ctr >= 2) begin
         tk = 1'b1;
         tg = m_btb[idx_of(a)].target;
      end
   endtask

   // ---------------- driver ----------------
   // k: 0 = non-control, 1 = branch, 2 = JAL, 3 = JALR
   task automatic drive(input logic r, input logic s, input logic v, input logic [1:0] k,
                        input logic z, input logic [31:0] epc, input logic [31:0] imm,
                        input logic [31:0] alu, input logic [31:0] eptgt);
      rst = r; stall = s; ex_valid = v; ex_zero = z;
      ex_is_branch = (k == 2'd1); ex_is_jal = (k == 2'd2); ex_is_jalr = (k == 2'd3);
      ex_pc = epc; ex_imm = imm; ex_aluout = alu; ex_pred_target = eptgt;
      ex_pred_taken = 1'b0;
   endtask

   // Called at the negedge: compares the DUT with the model, advances the
   // model by one clock, then moves to just after the next rising edge.
   task automatic step(input bit do_chk);
      logic        mtk, tkn, fl, ctl, plain, hit;
      logic [31:0] mtg, tgt, nxt;
      int          i;
      m_predict(m_pc, mtk, mtg);
      ctl   = ex_valid && (ex_is_branch || ex_is_jal || ex_is_jalr);
      plain = ex_valid && !(ex_is_branch || ex_is_jal || ex_is_jalr);
      tkn   = ex_is_jal || ex_is_jalr || (ex_is_branch && ex_zero);
      tgt   = ex_is_jalr ? (ex_aluout & ~32'd1) : (ex_pc + ex_imm);
      nxt   = tkn ? tgt : (ex_pc + 32'd4);
      fl    = !rst && ex_valid && (nxt != ex_pred_target);
      if (do_chk) begin
         chk("model_pc", pc, m_pc);
         chk("model_pred_taken", {31'd0, pred_taken}, {31'd0, mtk});
         chk("model_pred_target", pred_target, mtg);
         chk("model_flush", {31'd0, flush}, {31'd0, fl});
         chk("model_cnt", mispredict_cnt, m_cnt);
      end
      if (rst) begin
         m_btb.delete();
         m_pc  = RST_PC;
         m_cnt = '0;
      end else begin
         i   = idx_of(ex_pc);
         hit = m_hit(ex_pc);
         if (ctl) begin
            if (hit && tkn) begin
               m_btb[i].ctr    = (m_btb[i].ctr < 3) ? m_btb[i].ctr + 1 : 3;
               m_btb[i].target = tgt;
            end else if (hit) begin
               m_btb[i].ctr = (m_btb[i].ctr > 0) ? m_btb[i].ctr - 1 : 0;
            end else if (tkn) begin
               m_btb[i] = '{tag: tag_of(ex_pc), target: tgt, ctr: 2};
            end
         end else if (plain && fl && hit) begin
            m_btb.delete(i);
         end
         if (fl) begin
            if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
            m_pc = nxt;
         end else if (!stall) begin
            m_pc = mtg;
         end
      end
      @(posedge clk);
      #1;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic        r, s, v;
      logic [1:0]  k;
      logic        z;
      logic [31:0] epc, imm, alu, eptgt;
      logic [31:0] e_pc;
      logic        e_ptk;
      logic [31:0] e_ptgt;
      logic        e_flush;
      logic [31:0] e_cnt;
   } vec_t;

   vec_t tbl[23];

   initial begin
      //            r s v k z epc          imm           alu       eptgt     | pc        ptk ptgt     fl cnt
      tbl[0]  = '{1,0,1,1,1,32'h10,  32'h20,       32'h0,   32'h0,   32'h0,   0,32'h4,   0,0};
      tbl[1]  = '{0,0,0,0,0,32'h0,   32'h0,        32'h0,   32'h0,   32'h0,   0,32'h4,   0,0};
      tbl[2]  = '{0,0,0,0,0,32'h0,   32'h0,        32'h0,   32'h0,   32'h4,   0,32'h8,   0,0};
      tbl[3]  = '{0,0,0,0,0,32'h0,   32'h0,        32'h0,   32'h0,   32'h8,   0,32'hC,   0,0};
      tbl[4]  = '{0,0,1,1,1,32'h10,  32'h20,       32'h0,   32'h14,  32'hC,   0,32'h10,  1,0};
      tbl[5]  = '{0,0,1,2,0,32'h40,  32'hFFFFFFD0, 32'h0,   32'h44,  32'h30,  0,32'h34,  1,1};
      tbl[6]  = '{0,0,1,1,0,32'h10,  32'h20,       32'h0,   32'h30,  32'h10,  1,32'h30,  1,2};
      tbl[7]  = '{0,0,1,1,0,32'h10,  32'h20,       32'h0,   32'h14,  32'h14,  0,32'h18,  0,3};
      tbl[8]  = '{0,0,1,2,0,32'h20,  32'hFFFFFFF0, 32'h0,   32'h24,  32'h18,  0,32'h1C,  1,3};
      tbl[9]  = '{0,0,1,3,0,32'h200, 32'h0,        32'h101, 32'h204, 32'h10,  0,32'h14,  1,4};
      tbl[10] = '{0,0,1,2,0,32'h20,  32'hFFFFFFF0, 32'h0,   32'h10,  32'h100, 0,32'h104, 0,5};
      tbl[11] = '{0,1,1,1,1,32'h300, 32'h10,       32'h0,   32'h304, 32'h104, 0,32'h108, 1,5};
      tbl[12] = '{0,1,0,0,0,32'h0,   32'h0,        32'h0,   32'h0,   32'h310, 0,32'h314, 0,6};
      tbl[13] = '{0,1,0,0,0,32'h0,   32'h0,        32'h0,   32'h0,   32'h310, 0,32'h314, 0,6};
      tbl[14] = '{0,1,0,0,0,32'h0,   32'h0,        32'h0,   32'h0,   32'h310, 0,32'h314, 0,6};
      tbl[15] = '{0,0,1,1,1,32'h50,  32'h40,       32'h0,   32'h54,  32'h310, 0,32'h314, 1,6};
      tbl[16] = '{0,0,1,2,0,32'h20,  32'hFFFFFFF0, 32'h0,   32'h24,  32'h90,  0,32'h94,  1,7};
      tbl[17] = '{0,0,1,0,0,32'h20,  32'h0,        32'h0,   32'h10,  32'h10,  0,32'h14,  1,8};
      tbl[18] = '{0,0,1,0,0,32'h1C,  32'h0,        32'h0,   32'h0,   32'h24,  0,32'h28,  1,9};
      tbl[19] = '{1,0,1,1,1,32'h10,  32'h20,       32'h0,   32'h0,   32'h20,  0,32'h24,  0,10};
      tbl[20] = '{1,0,0,0,0,32'h0,   32'h0,        32'h0,   32'h0,   32'h0,   0,32'h4,   0,0};
      tbl[21] = '{0,0,1,0,0,32'h4C,  32'h0,        32'h0,   32'h0,   32'h0,   0,32'h4,   1,0};
      tbl[22] = '{0,0,0,0,0,32'h0,   32'h0,        32'h0,   32'h0,   32'h50,  0,32'h54,  0,1};
   end

   // ---------------- test sequence ----------------
   initial begin
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      @(negedge clk);
      step(0);

      // Directed table.
      for (int r = 0; r < 23; r++) begin
         drive(tbl[r].r, tbl[r].s, tbl[r].v, tbl[r].k, tbl[r].z,
               tbl[r].epc, tbl[r].imm, tbl[r].alu, tbl[r].eptgt);
         @(negedge clk);
         chk($sformatf("row%0d_pc", r), pc, tbl[r].e_pc);
         chk($sformatf("row%0d_pred_taken", r), {31'd0, pred_taken}, {31'd0, tbl[r].e_ptk});
         chk($sformatf("row%0d_pred_target", r), pred_target, tbl[r].e_ptgt);
         chk($sformatf("row%0d_flush", r), {31'd0, flush}, {31'd0, tbl[r].e_flush});
         chk($sformatf("row%0d_cnt", r), mispredict_cnt, tbl[r].e_cnt);
         step(1);
      end

      // Direction counter saturates at 3: allocate(2), taken(3), taken(3),
      // not-taken(2) must still predict taken.
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0);            @(negedge clk); step(1);
      drive(0, 0, 1, 1, 1, 32'h10, 32'h20, 0, 32'h14); @(negedge clk); step(1);
      drive(0, 0, 1, 1, 1, 32'h10, 32'h20, 0, 32'h30); @(negedge clk);
      chk("sat_no_flush", {31'd0, flush}, 32'd0);
      step(1);
      drive(0, 0, 1, 1, 1, 32'h10, 32'h20, 0, 32'h30); @(negedge clk); step(1);
      drive(0, 0, 1, 1, 0, 32'h10, 32'h20, 0, 32'h30); @(negedge clk);
      chk("sat_nt_flush", {31'd0, flush}, 32'd1);
      step(1);
      drive(0, 0, 1, 0, 0, 32'hC, 0, 0, 32'h0);        @(negedge clk); step(1);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);                @(negedge clk);
      chk("sat_pc", pc, 32'h10);
      chk("sat_pred_taken", {31'd0, pred_taken}, 32'd1);
      chk("sat_pred_target", pred_target, 32'h30);
      step(1);

      // Random traffic against the model.
      for (int n = 0; n < 400; n++) begin
         logic        tk;
         logic [31:0] tg, epc, eptgt;
         int          sel;
         epc = 32'($urandom_range(0, 63)) * 32'd4;
         m_predict(epc, tk, tg);
         sel = int'($urandom_range(0, 2));
         eptgt = (sel == 0) ? tg : (sel == 1) ? epc + 32'd4 : 32'($urandom_range(0, 63)) * 32'd4;
         drive($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
               2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), epc,
               32'($urandom_range(0, 31)) * 32'd4 - 32'd64, 32'($urandom_range(0, 255)), eptgt);
         ex_pred_taken = tk;
         @(negedge clk);
         step(1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/npc_bp.md
Name: npc_bp

Overview:
- Parametrised next-PC generator with a direct-mapped branch target buffer (BTB) and 2-bit saturating direction counters.
- Owns the fetch PC register and predicts the next fetch address every cycle.
- Resolves branch, JAL and JALR in EX. Issues a one-cycle redirect plus flush on misprediction.
- Successor to the combinational next-PC selector. Sits between IF (PC register) and EX (resolution feedback) in the pipelined CPU.

Parameters:
- XLEN, 32, address/data width.
- BTB_ENTRIES, 16, number of BTB entries. Must be a power of 2, ≥2. IDX = log2(BTB_ENTRIES).
- RESET_PC, 32'h0000_0000, fetch address after reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold fetch PC (IF/ID stall).
- pc  out  XLEN  current fetch PC (registered).
- pred_taken  out  1  prediction for the current pc.
- pred_target  out  XLEN  predicted next PC for the current pc. Pipelined down to EX by the caller.
- ex_valid  in  1  EX stage holds a valid instruction.
- ex_pc  in  XLEN  PC of the EX instruction.
- ex_is_branch  in  1  conditional branch in EX.
- ex_is_jal  in  1  JAL in EX.
- ex_is_jalr  in  1  JALR in EX.
- ex_zero  in  1  branch condition true (ALU Zero).
- ex_imm  in  XLEN  immediate of the EX instruction.
- ex_aluout  in  XLEN  ALU result (JALR target).
- ex_pred_taken  in  1  pred_taken that travelled with the EX instruction.
- ex_pred_target  in  XLEN  pred_target that travelled with the EX instruction.
- flush  out  1  mispredict. Caller kills IF/ID and ID/EX.
- mispredict_cnt  out  32  saturating count of redirects.

Behaviour:

Indexing
- idx = pc[IDX+1:2].
- tag = pc[XLEN-1:IDX+2].
- Entry fields: valid, tag, target[XLEN-1:0], ctr[1:0].

Prediction (combinational on pc)
- hit = valid & (tag match).
- pred_taken = hit & ctr[1].
- pred_target = pred_taken ? entry.target : pc+4. Add wraps modulo 2^XLEN.

Resolution (combinational, EX)
- ctl = ex_valid & (ex_is_branch | ex_is_jal | ex_is_jalr).
- act_taken = ex_is_jal | ex_is_jalr | (ex_is_branch & ex_zero).
- act_target:
  - JALR: ex_aluout & ~1.
  - Otherwise: ex_pc + ex_imm.
- act_next = act_taken ? act_target : ex_pc+4.
- flush = ex_valid & (act_next != ex_pred_target). This covers both direction and target mispredicts, and a non-control instruction that aliased to a taken BTB entry.

Next PC (registered on rising clk), priority order
1. rst: pc ← RESET_PC.
2. flush: pc ← act_next. Redirect overrides stall.
3. stall: pc holds.
4. Otherwise: pc ← pred_target.

BTB update (rising clk, when ctl & !rst), index/tag from ex_pc
- Hit, taken: ctr saturating +1 (max 3), target ← act_target.
- Hit, not taken: ctr saturating −1 (min 0). Target unchanged.
- Miss, taken: allocate. valid=1, tag, target=act_target, ctr=2'b10. Overwrites the previous entry.
- Miss, not taken: no change.
- Non-control instruction with flush (alias): invalidate the entry at ex_pc's index if its tag matches.
- Same-cycle lookup and update to the same index: lookup sees the old contents (no bypass). The update is visible the next cycle.
- stall does not block the BTB update.

mispredict_cnt
- +1 on every cycle with flush=1.
- Saturates at 32'hFFFF_FFFF.

Reset
- pc=RESET_PC.
- All valid=0, all ctr=2'b01.
- mispredict_cnt=0.
- flush is 0 during reset because ex_valid is ignored while rst=1.
- Reset mid-operation discards any pending redirect.

Latency
- Prediction: 0 cycles (same cycle as pc).
- Redirect: pc takes act_next on the edge following the EX cycle.

Test Plan:
- Reset → pc=0, pred_taken=0, pred_target=4. Free-run 3 cycles → pc=4,8,12.
- Cold taken branch: ex_pc=0x10, ex_is_branch=1, ex_zero=1, ex_imm=0x20, ex_pred_target=0x14 → flush=1, next pc=0x30, entry idx 4 allocated with ctr=2. Later pc=0x10 → pred_taken=1, pred_target=0x30.
- Same branch resolves not-taken twice with correct prediction inputs → first: flush=1, next pc=0x14, ctr=1. Second: no flush, ctr=0. Then pc=0x10 predicts 0x14.
- JALR: ex_aluout=0x101, ex_pred_target=ex_pc+4 → flush=1, next pc=0x100. Correctly predicted JAL → flush=0, mispredict_cnt unchanged.
- stall=1 with flush=1 in the same cycle → pc takes act_next. stall=1 alone → pc holds for 3 cycles.
- Two PCs aliasing to the same index with different tags (0x10, 0x50 when BTB_ENTRIES=16) → the second allocation replaces the first, and 0x10 then misses. Assert rst mid-stream → pc=RESET_PC and all predictions are not-taken.
